// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline stage register:
//                control state encodings and the default nop payload.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // State encodings double as the occupancy count (0, 1 or 2 entries).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } pipe_state_t;

    // All-zero word is the MIPS nop; used as the default clear value.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_dffe.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_dffe
//  Description : WIDTH-bit register with clock enable and synchronous
//                active-high clear (clear wins over enable).
//  Ports       : clk - rising-edge clock
//                clr - synchronous clear, loads RESET_VAL
//                en  - load enable
//                d   - next value
//                q   - registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_dffe
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_WORD)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_dffe
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Valid/ready pipeline stage register with a two-entry skid
//                buffer, synchronous flush and occupancy count. All outputs
//                come straight from flops; in_ready never depends on
//                out_ready combinationally.
//  Ports       : clk       - rising-edge clock
//                clr       - synchronous active-high reset
//                flush     - synchronous squash of held entries
//                in_valid  - upstream has data
//                in_ready  - stage accepts data this cycle
//                in_data   - upstream payload
//                out_valid - stage presents data
//                out_ready - downstream accepts data this cycle
//                out_data  - payload to downstream (main register)
//                count     - entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_WORD)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic             w_clear;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] r_main_q;
    logic [WIDTH-1:0] r_skid_q;

    // clr and flush have the same effect on the datapath; any in-transfer
    // on the same edge is simply dropped.
    assign w_clear = clr | flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_main_en    = 1'b0;
        w_skid_en    = 1'b0;
        w_main_d     = in_data;
        case (r_state)
            S_EMPTY: begin
                if (in_valid) begin
                    w_main_en    = 1'b1;
                    w_next_state = S_ONE;
                end
            end
            S_ONE: begin
                if (out_ready && in_valid) begin
                    w_main_en = 1'b1;
                end else if (out_ready) begin
                    w_next_state = S_EMPTY;
                end else if (in_valid) begin
                    // Downstream stalled while in_ready was still high:
                    // park the extra entry in the skid register.
                    w_skid_en    = 1'b1;
                    w_next_state = S_TWO;
                end
            end
            S_TWO: begin
                // in_ready is low here, so in_valid is irrelevant.
                if (out_ready) begin
                    w_main_en    = 1'b1;
                    w_main_d     = r_skid_q;
                    w_next_state = S_ONE;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    pipe_dffe #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .clr (w_clear),
        .en  (w_main_en),
        .d   (w_main_d),
        .q   (r_main_q)
    );

    pipe_dffe #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk (clk),
        .clr (w_clear),
        .en  (w_skid_en),
        .d   (in_data),
        .q   (r_skid_q)
    );

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = (r_state != S_TWO);
    // State encoding equals the number of held entries.
    assign count     = 2'(r_state);
    assign out_data  = r_main_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A queue model of
//                the held entries predicts every output each cycle; directed
//                sequences add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          WIDTH     = 32;
    localparam logic [31:0] RESET_VAL = 32'h0;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: ordered list of held payloads, plus the value the
    // output register shows when nothing is held.
    // ------------------------------------------------------------------
    logic [31:0] model_q[$];
    logic [31:0] model_head = RESET_VAL;
    bit          held_flag  = 1'b0;
    logic [31:0] held_data  = '0;
    bit          check_en   = 1'b0;

    always @(posedge clk) begin
        int pre;
        pre       = model_q.size();
        held_flag = (pre > 0) && !out_ready && !clr && !flush;
        held_data = (pre > 0) ? model_q[0] : model_head;
        if (clr || flush) begin
            model_q.delete();
            model_head = RESET_VAL;
        end else begin
            if (pre > 0 && out_ready) void'(model_q.pop_front());
            if (in_valid && pre < 2) model_q.push_back(in_data);
            if (model_q.size() > 0) model_head = model_q[0];
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
            chk("in_ready",  {31'd0, in_ready},  {31'd0, model_q.size() < 2});
            chk("count",     {30'd0, count},     32'(model_q.size()));
            chk("out_data",  out_data,           model_head);
            if (count > 2'd2) chk("count_range", {30'd0, count}, 32'd2);
            if (held_flag) chk("stall_hold", out_data, held_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        // ---------------- reset ----------------
        clr = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        check_en = 1'b1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_data",  out_data, 32'h0);
        tick();
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_data",  out_data, 32'h0);
        clr = 1'b0;
        tick();
        chk("first_accept_data",  out_data, 32'hDEADBEEF);
        chk("first_accept_count", {30'd0, count}, 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- streaming ----------------
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            tick();
            chk("stream_data",  out_data, 32'(i));
            chk("stream_count", {30'd0, count}, 32'd1);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- back-pressure ----------------
        drive(1'b1, 32'hA, 1'b1);
        tick();
        chk("bp_main", out_data, 32'hA);
        drive(1'b1, 32'hB, 1'b0);
        tick();
        chk("bp_count2", {30'd0, count}, 32'd2);
        chk("bp_ready0", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b0);
        tick();
        chk("bp_c_rejected", {30'd0, count}, 32'd2);
        chk("bp_hold_a2", out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b1);
        tick();
        chk("bp_out_b", out_data, 32'hB);
        chk("bp_count1", {30'd0, count}, 32'd1);
        tick();
        chk("bp_out_c", out_data, 32'hC);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- flush ----------------
        drive(1'b1, 32'h10, 1'b0);
        tick();
        drive(1'b1, 32'h11, 1'b0);
        tick();
        chk("fl_count2", {30'd0, count}, 32'd2);
        chk("fl_main",   out_data, 32'h10);
        flush = 1'b1;
        drive(1'b1, 32'h12, 1'b0);
        tick();
        flush = 1'b0;
        chk("fl_count0", {30'd0, count}, 32'd0);
        chk("fl_valid0", {31'd0, out_valid}, 32'd0);
        chk("fl_data",   out_data, RESET_VAL);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("fl_no_12", {31'd0, out_valid}, 32'd0);

        // ---------------- random ----------------
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 3);
            clr       = ($urandom_range(0, 999) < 5);
            tick();
        end
        clr = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        tick();
        tick();
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the multi-cycle/pipelined CPU datapath. It generalises the plain 32-bit D flip-flop stage to any width. It adds a valid/ready handshake, a two-entry skid buffer so back-pressure never needs a combinational ready path, a synchronous flush for branch/hazard squash, and an occupancy count. It sits between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- WIDTH, 32: payload width in bits (≥1).
- RESET_VAL, 0: value loaded into both data registers on clear or flush (0 = MIPS nop).
- clk  input  1  rising-edge clock, sole clock.
- clr  input  1  synchronous, active-high reset; sampled on rising clk edge.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage accepts data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents data.
- out_ready  input  1  downstream accepts data this cycle.
- out_data  output  WIDTH  payload to downstream.
- count  output  2  entries held (0..2).

## Operation
- Transfers: in-transfer = in_valid & in_ready at a rising edge; out-transfer = out_valid & out_ready at a rising edge.
- Storage: main register (drives out_data) and skid register.
- States: EMPTY (count 0), ONE (main full), TWO (main and skid full).
- Outputs are pure functions of state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - count = 0/1/2.
- EMPTY:
  - in_valid → main<=in_data, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - out_ready & in_valid → main<=in_data, stay in ONE.
  - out_ready & !in_valid → go to EMPTY.
  - !out_ready & in_valid → skid<=in_data, go to TWO.
  - Neither → hold.
- TWO:
  - out_ready → main<=skid, go to ONE.
  - Otherwise hold.
  - in_valid is ignored because in_ready=0.
- Priority: clr > flush > normal operation.
- clr or flush → state EMPTY, main and skid set to RESET_VAL.
  - Any simultaneous in-transfer is dropped.
  - A simultaneous out-transfer still counts as completed for the downstream side, since it sampled out_valid before the edge.
- Ordering: data leaves in acceptance order; no entry is duplicated or lost except by flush/clr.
- Payload is opaque; no arithmetic on it.

## Timing
- Reset values after clr: out_valid=0, in_ready=1, count=0, out_data=RESET_VAL.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one transfer per cycle sustained while out_ready=1.
- in_ready is registered state and has no combinational dependence on out_ready.
  - Consequence: one extra entry is absorbed after downstream deasserts out_ready.
  - Upstream observes in_ready=0 from the cycle after the stall begins.
- No combinational path from any input to any output; out_data comes straight from a flop.
- Holding: upstream need not hold in_data after an in-transfer. Downstream sees out_data stable while out_valid & !out_ready.
- Mid-operation clr behaves identically to flush plus state reset; the first accept is possible at the edge after clr deasserts.

## Structure
- Shared package pipe_pkg: state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2, plus the default nop constant used for RESET_VAL.
- One natural sub-module: pipe_dffe (WIDTH, RESET_VAL). It is a register with clock enable and synchronous active-high clear, instantiated twice (main, skid).
- Control: a 2-bit state register plus next-state logic in the top module.

## Test plan
- Reset: hold clr 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, in_ready=1, count=0, out_data=0 throughout; first accept on the edge after clr drops.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 on the next three cycles, count stays 1, in_ready stays 1.
- Back-pressure: with main=0xA, drop out_ready and push 0xB then 0xC → 0xB absorbed into skid, count=2, in_ready=0, 0xC not accepted; raise out_ready → out sequence 0xA,0xB, then 0xC accepted.
- Flush: in TWO with 0x10/0x11 held, assert flush together with in_valid=1, in_data=0x12 → next cycle count=0, out_valid=0, out_data=RESET_VAL, and 0x12 is never emitted.
- Random: random in_valid/out_ready/flush over 10k cycles with a scoreboard model → output order matches input order minus flushed entries; count never exceeds 2; out_data stable while stalled.
